// File: rtl/dct4_transpose_buf.sv
// -----------------------------------------------------------------------------
// dct4_transpose_buf
//
// Row-to-column transpose stage that follows the 4-point DCT butterfly.
// Each accepted row of four signed WIDTH_Y coefficients is rounded,
// right-shifted by SHIFT and reduced to WIDTH_O bits. It is then written
// into one bank of a 4x4 ping-pong buffer. A full bank is read out column
// by column, so the second 1-D pass receives transposed data. While one
// bank drains, the other bank fills, which sustains one row in and one
// column out per cycle.
//
// Optional feature: define TRANSPOSE_SAT_EN to saturate the shifted value
// to the WIDTH_O signed range. When it is undefined, the value keeps its
// low WIDTH_O bits and wraps in two's complement.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst_b          asynchronous active-low reset
//   in_valid       input row valid
//   in_ready       the current write bank can accept a row
//   in_y0..in_y3   signed row coefficients, column index 0..3
//   out_valid      output column valid
//   out_ready      downstream accepts the column
//   out_c0..out_c3 signed column coefficients, row index 0..3
//   out_last       high together with column 3 of a block
// -----------------------------------------------------------------------------
module dct4_transpose_buf #(
    parameter int WIDTH_Y = 17,
    parameter int WIDTH_O = 16,
    parameter int SHIFT   = 1
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH_Y-1:0] in_y0,
    input  logic signed [WIDTH_Y-1:0] in_y1,
    input  logic signed [WIDTH_Y-1:0] in_y2,
    input  logic signed [WIDTH_Y-1:0] in_y3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH_O-1:0] out_c0,
    output logic signed [WIDTH_O-1:0] out_c1,
    output logic signed [WIDTH_O-1:0] out_c2,
    output logic signed [WIDTH_O-1:0] out_c3,
    output logic                      out_last
);

    // One guard bit above the input width, so that adding the rounding
    // constant can never overflow.
    localparam int WV = WIDTH_Y + 1;

    // The inner conditional keeps the shift amount non-negative when
    // SHIFT is 0.
    localparam logic signed [WV-1:0] RND =
        (SHIFT > 0) ? (WV'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

`ifdef TRANSPOSE_SAT_EN
    localparam logic signed [WV-1:0] SAT_MAX = WV'((64'sd1 <<< (WIDTH_O - 1)) - 64'sd1);
    localparam logic signed [WV-1:0] SAT_MIN = -SAT_MAX - WV'(1);
`endif

    typedef logic signed [WIDTH_O-1:0] coef_t;

    // Round, shift, then reduce one coefficient to the stored width.
    function automatic coef_t reduce_coef(input logic signed [WIDTH_Y-1:0] x);
        logic signed [WV-1:0] v;
        v = WV'(x) + RND;
`ifdef TRANSPOSE_SAT_EN
        v = v >>> SHIFT;
        if (v > SAT_MAX)      reduce_coef = SAT_MAX[WIDTH_O-1:0];
        else if (v < SAT_MIN) reduce_coef = SAT_MIN[WIDTH_O-1:0];
        else                  reduce_coef = v[WIDTH_O-1:0];
`else
        reduce_coef = WIDTH_O'(v >>> SHIFT);
`endif
    endfunction

    // Indexing order: [bank][row][column]
    coef_t       mem_q [2][4][4];
    coef_t       wr_data [4];
    logic [1:0]  full_q,    full_d;
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic [1:0]  wr_row_q,  wr_row_d;
    logic [1:0]  rd_col_q,  rd_col_d;
    logic        wr_fire, rd_fire;

    assign wr_data[0] = reduce_coef(in_y0);
    assign wr_data[1] = reduce_coef(in_y1);
    assign wr_data[2] = reduce_coef(in_y2);
    assign wr_data[3] = reduce_coef(in_y3);

    // Both handshake signals depend only on registered state, so
    // in_ready never combinationally follows in_valid.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    assign out_c0   = mem_q[rd_bank_q][0][rd_col_q];
    assign out_c1   = mem_q[rd_bank_q][1][rd_col_q];
    assign out_c2   = mem_q[rd_bank_q][2][rd_col_q];
    assign out_c3   = mem_q[rd_bank_q][3][rd_col_q];
    assign out_last = (rd_col_q == 2'd3);

    // NOTE: every output of this block gets its default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        // A write always targets a non-full bank and a read always targets
        // a full bank. The two updates of full_d therefore never hit the
        // same bit.
        if (wr_fire) begin
            wr_row_d = wr_row_q + 2'd1;
            if (wr_row_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire) begin
            rd_col_d = rd_col_q + 2'd1;
            if (rd_col_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    // NOTE: state uses non-blocking assignments only. Every register then
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // NOTE: the storage words are cleared on reset on purpose. The outputs
    // read the memory directly, so out_c* must show 0 after reset, and no
    // stale block may leak out.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        mem_q[b][r][c] <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < 4; c++)
                mem_q[wr_bank_q][wr_row_q][c] <= wr_data[c];
        end
    end

endmodule

// File: tb/tb_dct4_transpose_buf.sv
// -----------------------------------------------------------------------------
// tb_dct4_transpose_buf
//
// Drives two instances in lockstep from the same stimulus: u_s0 has SHIFT=0
// and u_s1 has SHIFT=1. The two instances share the handshake inputs, and
// their handshake outputs do not depend on data. The monitor pushes the
// expected columns into a scoreboard when the fourth row of a block is
// accepted, and pops and compares them when a column is consumed. Inputs
// change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dct4_transpose_buf;

    localparam int WY = 17;
    localparam int WO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b, in_valid, out_ready;
    logic signed [WY-1:0] in_y0, in_y1, in_y2, in_y3;

    logic a_in_ready, a_out_valid, a_out_last;
    logic signed [WO-1:0] a_c0, a_c1, a_c2, a_c3;
    logic b_in_ready, b_out_valid, b_out_last;
    logic signed [WO-1:0] b_c0, b_c1, b_c2, b_c3;

    dct4_transpose_buf #(.WIDTH_Y(WY), .WIDTH_O(WO), .SHIFT(0)) u_s0 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_y0(in_y0), .in_y1(in_y1), .in_y2(in_y2), .in_y3(in_y3),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_c0(a_c0), .out_c1(a_c1), .out_c2(a_c2), .out_c3(a_c3),
        .out_last(a_out_last)
    );

    dct4_transpose_buf #(.WIDTH_Y(WY), .WIDTH_O(WO), .SHIFT(1)) u_s1 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_y0(in_y0), .in_y1(in_y1), .in_y2(in_y2), .in_y3(in_y3),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_c0(b_c0), .out_c1(b_c1), .out_c2(b_c2), .out_c3(b_c3),
        .out_last(b_out_last)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_cols   = 0;
    int stall_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference transform: round, arithmetic shift, then reduce to WO bits.
    function automatic int xform(input int x, input int sh);
        int v;
        logic signed [WO-1:0] t;
        v = x + ((sh > 0) ? (1 << (sh - 1)) : 0);
        v = v >>> sh;
`ifdef TRANSPOSE_SAT_EN
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
`else
        t = v[WO-1:0];
        return int'(t);
`endif
    endfunction

    typedef struct {
        int  a [4];
        int  b [4];
        bit  last;
    } col_t;

    col_t sb [$];
    int   rows [4][4];
    int   n_rows = 0;
    col_t exp_col;
    col_t new_col;

    // Scoreboard monitor: it compares consumed columns and captures accepted rows.
    always @(negedge clk) begin
        if (rst_b) begin
            if (a_out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_column", 1, 0);
                end else begin
                    exp_col = sb.pop_front();
                    check("s0_c0", int'(a_c0), exp_col.a[0]);
                    check("s0_c1", int'(a_c1), exp_col.a[1]);
                    check("s0_c2", int'(a_c2), exp_col.a[2]);
                    check("s0_c3", int'(a_c3), exp_col.a[3]);
                    check("s0_last", int'(a_out_last), int'(exp_col.last));
                    check("s1_valid", int'(b_out_valid), 1);
                    check("s1_c0", int'(b_c0), exp_col.b[0]);
                    check("s1_c1", int'(b_c1), exp_col.b[1]);
                    check("s1_c2", int'(b_c2), exp_col.b[2]);
                    check("s1_c3", int'(b_c3), exp_col.b[3]);
                    check("s1_last", int'(b_out_last), int'(exp_col.last));
                    n_cols++;
                end
            end
            if (in_valid && a_in_ready) begin
                check("s1_in_ready", int'(b_in_ready), 1);
                rows[n_rows][0] = int'(in_y0);
                rows[n_rows][1] = int'(in_y1);
                rows[n_rows][2] = int'(in_y2);
                rows[n_rows][3] = int'(in_y3);
                n_rows++;
                if (n_rows == 4) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int r = 0; r < 4; r++) begin
                            new_col.a[r] = xform(rows[r][c], 0);
                            new_col.b[r] = xform(rows[r][c], 1);
                        end
                        new_col.last = (c == 3);
                        sb.push_back(new_col);
                    end
                    n_rows = 0;
                end
            end
        end
    end

    // Offer one row until it is accepted. The task returns 1 time unit
    // after the accepting edge.
    task automatic send_row(input int y0, input int y1, input int y2, input int y3);
        in_y0 = WY'(y0); in_y1 = WY'(y1); in_y2 = WY'(y2); in_y3 = WY'(y3);
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (a_in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            stall_cnt++;
            @(posedge clk);
            #1;
        end
        check("send_row_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Block with a recognisable pattern: element (r,c) = base + 10*r + c.
    task automatic send_block(input int base);
        for (int r = 0; r < 4; r++)
            send_row(base + 10*r, base + 10*r + 1, base + 10*r + 2, base + 10*r + 3);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && sb.size() != 0; c++)
            @(negedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s0_valid"}, int'(a_out_valid), 0);
        check({tag, "_s0_last"},  int'(a_out_last), 0);
        check({tag, "_s0_c0"},    int'(a_c0), 0);
        check({tag, "_s0_c3"},    int'(a_c3), 0);
        check({tag, "_s0_ready"}, int'(a_in_ready), 1);
        check({tag, "_s1_valid"}, int'(b_out_valid), 0);
        check({tag, "_s1_c1"},    int'(b_c1), 0);
        check({tag, "_s1_ready"}, int'(b_in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int cols_before;

    initial begin
        rst_b = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_y0 = '0; in_y1 = '0; in_y2 = '0; in_y3 = '0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Transpose: row 4 accepted at edge E, out_valid visible right after E.
        send_row(1, 2, 3, 4);
        send_row(5, 6, 7, 8);
        send_row(9, 10, 11, 12);
        check("latency_before", int'(a_out_valid), 0);
        send_row(13, 14, 15, 16);
        check("latency_after", int'(a_out_valid), 1);
        check("transpose_c0", int'(a_c0), 1);
        check("transpose_c3", int'(a_c3), 13);
        wait_drain();

        // Rounding with SHIFT=1: column outputs 2, -1, 1, 0.
        send_row(3, -3, 1, -1);
        send_row(0, 0, 0, 0);
        send_row(0, 0, 0, 0);
        send_row(0, 0, 0, 0);
        check("round_col0", int'(b_c0), 2);
        wait_drain();

        // Saturation / wrap on the SHIFT=0 instance.
        send_row(40000, -40000, 0, 0);
        send_row(-40000, 40000, 0, 0);
        send_row(0, 0, 0, 0);
        send_row(0, 0, 0, 0);
`ifdef TRANSPOSE_SAT_EN
        check("sat_pos", int'(a_c0), 32767);
        check("sat_neg", int'(a_c1), -32768);
`else
        check("wrap_pos", int'(a_c0), -25536);
        check("wrap_neg", int'(a_c1), 25536);
`endif
        wait_drain();

        // Ping-pong throughput: three back-to-back blocks, no stalls.
        stall_cnt   = 0;
        cols_before = n_cols;
        send_block(100);
        send_block(200);
        send_block(300);
        wait_drain();
        check("throughput_stalls", stall_cnt, 0);
        check("throughput_cols", n_cols - cols_before, 12);

        // Backpressure: two blocks fill both banks, and row 9 stalls.
        out_ready = 1'b0;
        stall_cnt = 0;
        send_block(400);
        send_block(500);
        check("bp_fill_stalls", stall_cnt, 0);
        in_y0 = WY'(600); in_y1 = WY'(601); in_y2 = WY'(602); in_y3 = WY'(603);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", int'(a_in_ready), 0);
            check("bp_valid", int'(a_out_valid), 1);
            check("bp_hold_c0", int'(a_c0), 400);
            check("bp_hold_c1", int'(a_c1), 410);
            check("bp_hold_c2", int'(a_c2), 420);
            check("bp_hold_c3", int'(a_c3), 430);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_still_stalled", int'(a_in_ready), 0);
        end
        @(negedge clk);
        check("bp_ready_returns", int'(a_in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_row(610, 611, 612, 613);
        send_row(620, 621, 622, 623);
        send_row(630, 631, 632, 633);
        wait_drain();

        // Asynchronous reset in the middle of row 2 of a block, with one full bank pending.
        out_ready = 1'b0;
        send_block(700);
        send_row(800, 801, 802, 803);
        send_row(810, 811, 812, 813);
        in_y0 = WY'(820); in_y1 = WY'(821); in_y2 = WY'(822); in_y3 = WY'(823);
        in_valid = 1'b1;
        #1;
        rst_b = 1'b0;
        #1;
        check_idle("async_rst");
        sb.delete();
        n_rows = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cols_before = n_cols;
        send_block(900);
        check("post_rst_c0", int'(a_c0), 900);
        wait_drain();
        check("post_rst_cols", n_cols - cols_before, 4);
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(a_out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
